// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island packet geometry and the BCH(64,56)/(32,24) parity step.
// G(x) = 1 + x^6 + x^7 + x^8, processed LSB first.
package hdmi_pkg;

    localparam int PACKET_CYCLES    = 32;
    localparam int HEADER_DATA_BITS = 24;
    localparam int SUB_DATA_BITS    = 56;
    localparam int SUB_COUNT        = 4;
    localparam logic [7:0] BCH_POLY = 8'h83;

    typedef logic [HEADER_DATA_BITS-1:0] header_t;
    typedef logic [SUB_DATA_BITS-1:0]    sub_t;

    function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic data_bit);
        return (ecc >> 1) ^ ((ecc[0] ^ data_bit) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/packet_assembler_if.sv
// Upstream packet source <-> assembler bundle: held packet contents in, TMDS bits out.
interface packet_assembler_if;
    import hdmi_pkg::*;

    logic                   data_island_period;
    header_t                header;
    sub_t [SUB_COUNT-1:0]   sub;
    logic [4:0]             counter;
    logic [8:0]             packet_data;
    logic                   packet_data_valid;

    modport master (
        output data_island_period, header, sub,
        input  counter, packet_data, packet_data_valid
    );

    modport slave (
        input  data_island_period, header, sub,
        output counter, packet_data, packet_data_valid
    );

endinterface

// File: rtl/bch_ecc_8.sv
// One 8-bit BCH parity accumulator; consumes BITS_PER_CYCLE bits per update, bit 0 first.
module bch_ecc_8
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      update,
    input  logic [BITS_PER_CYCLE-1:0] data_bits,
    output logic [7:0]                ecc
);

    logic [7:0] ecc_next;

    always_comb begin
        ecc_next = ecc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            ecc_next = ecc_step(ecc_next, data_bits[i]);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)       ecc <= 8'h00;
        else if (clear)  ecc <= 8'h00;
        else if (update) ecc <= ecc_next;
    end

endmodule

// File: rtl/packet_assembler.sv
// Serialises one HDMI data-island packet over 32 pixel clocks, appending BCH parity
// to the header (cycles 24..31) and to each subpacket (cycles 28..31).
module packet_assembler
    import hdmi_pkg::*;
(
    input  logic                clk_pixel,
    input  logic                reset,
    packet_assembler_if.slave   bus
);

    logic [4:0]                 count;
    logic [7:0]                 header_ecc;
    logic [SUB_COUNT-1:0][7:0]  sub_ecc;
    logic                       in_header_data;
    logic                       in_sub_data;
    logic                       clear_ecc;
    logic [8:0]                 data_comb;
    logic [8:0]                 packet_data_r;
    logic                       valid_r;

    assign in_header_data = count < 5'(HEADER_DATA_BITS);
    assign in_sub_data    = count < 5'(SUB_DATA_BITS / 2);
    // Clearing on the last cycle makes the next packet start from a zero syndrome.
    assign clear_ecc      = !bus.data_island_period || count == 5'(PACKET_CYCLES - 1);

    always_comb begin
        data_comb = '0;
        data_comb[0] = in_header_data ? bus.header[count] : header_ecc[count[2:0]];
        for (int k = 0; k < SUB_COUNT; k++) begin
            if (in_sub_data) begin
                data_comb[1+k] = bus.sub[k][{count, 1'b0}];
                data_comb[5+k] = bus.sub[k][{count, 1'b1}];
            end else begin
                data_comb[1+k] = sub_ecc[k][{count[1:0], 1'b0}];
                data_comb[5+k] = sub_ecc[k][{count[1:0], 1'b1}];
            end
        end
    end

    bch_ecc_8 #(.BITS_PER_CYCLE(1)) u_header_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (clear_ecc),
        .update    (bus.data_island_period && in_header_data),
        .data_bits (data_comb[0]),
        .ecc       (header_ecc)
    );

    for (genvar k = 0; k < SUB_COUNT; k++) begin : g_sub_ecc
        bch_ecc_8 #(.BITS_PER_CYCLE(2)) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .clear     (clear_ecc),
            .update    (bus.data_island_period && in_sub_data),
            .data_bits ({data_comb[5+k], data_comb[1+k]}),
            .ecc       (sub_ecc[k])
        );
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            count         <= 5'd0;
            packet_data_r <= 9'd0;
            valid_r       <= 1'b0;
        end else begin
            count         <= bus.data_island_period ? count + 5'd1 : 5'd0;
            packet_data_r <= bus.data_island_period ? data_comb : 9'd0;
            valid_r       <= bus.data_island_period;
        end
    end

    assign bus.counter           = count;
    assign bus.packet_data       = packet_data_r;
    assign bus.packet_data_valid = valid_r;

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 The block SHALL have no parameters; all packet geometry constants come from the shared package.
REQ-002 clk_pixel  input  1  pixel clock, the only clock; all logic on rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 data_island_period  input  1  high while packet cycles are transmitted.
REQ-005 header  input  24  packet header HB0..HB2, LSB first; held stable by upstream for the whole packet.
REQ-006 sub  input  4x56  subpackets 0..3, LSB first; held stable for the whole packet.
REQ-007 counter  output  5  index (0..31) of the packet cycle being assembled; upstream uses counter==31 to swap packets.
REQ-008 packet_data  output  9  registered TMDS data-island bits: [0] header bit, [4:1] even bit of sub0..3, [8:5] odd bit of sub0..3.
REQ-009 packet_data_valid  output  1  packet_data holds a packet cycle.

Function
REQ-010 While data_island_period=1, counter SHALL increment by 1 per clk_pixel and wrap 31->0 with no idle cycle.
REQ-011 While data_island_period=0, counter SHALL be forced to 0 and all ECC registers cleared to 8'h00 on the next edge.
REQ-012 Packet cycle c (0..23): header bit = header[c]; header ECC updated with that bit.
REQ-013 Packet cycle c (24..31): header bit = header_ecc[c-24]; header ECC not updated.
REQ-014 Packet cycle c (0..27): sub k even bit = sub[k][2c], odd bit = sub[k][2c+1]; sub k ECC updated with even bit, then odd bit, in the same cycle.
REQ-015 Packet cycle c (28..31): sub k even bit = sub_ecc[k][2(c-28)], odd bit = sub_ecc[k][2(c-28)+1].
REQ-016 ECC step: next = (ecc >> 1) XOR (ecc[0] XOR bit ? 8'h83 : 8'h00), i.e. BCH G(x)=1+x^6+x^7+x^8.
REQ-017 All five ECC registers SHALL clear to 8'h00 at the edge where counter wraps 31->0, so back-to-back packets are independent.
REQ-018 packet_data and packet_data_valid SHALL be registered: bits for cycle c appear exactly one clk_pixel after counter=c is presented.
REQ-019 packet_data_valid SHALL equal data_island_period delayed by one cycle; when 0, packet_data SHALL be 9'd0.
REQ-020 data_island_period falling mid-packet SHALL abort: partial packet discarded, next assertion restarts at counter 0 with cleared ECC.
REQ-021 ECC update SHALL use the same-cycle data bits (no extra pipeline), so parity for cycle 24/28 reflects all preceding data bits.

Reset
REQ-022 On reset assertion, immediately: counter=0, all ECC=8'h00, packet_data=9'd0, packet_data_valid=0.
REQ-023 Reset mid-packet SHALL discard the packet; after release, the first packet starts at counter 0.

Structure
REQ-024 hdmi_pkg SHALL hold PACKET_CYCLES=32, HEADER_DATA_BITS=24, SUB_DATA_BITS=56, BCH_POLY=8'h83 and the single-bit ECC step function.
REQ-025 One sub-module bch_ecc_8 (parameter BITS_PER_CYCLE 1 or 2) SHALL hold one ECC register with clear/update enables; instantiated once for header (1) and four times for subpackets (2).

Verification
REQ-026 header=0, sub=0, island held 32 cycles -> packet_data=9'd0 for all 32 valid cycles, valid high cycles 1..32.
REQ-027 header=24'h000001, sub=0 -> cycle 0 packet_data[0]=1; header ECC=8'h4A; cycles 24..31 packet_data[0]=0,1,0,1,0,0,1,0.
REQ-028 sub[2]=56'h3 -> cycle 0 packet_data[3]=1 and [7]=1, other subs' bits 0; sub2 parity cycles 28..31 match software model of REQ-016.
REQ-029 island held 64 cycles, two different packets -> counter 0..31,0..31, second packet parity independent of first (matches model).
REQ-030 island dropped at counter=10, reasserted 3 cycles later -> counter restarts 0, valid low 3 cycles, parity matches fresh packet.
REQ-031 reset pulsed at counter=17 -> outputs zero immediately; after release and island high, full correct packet from counter 0.
